priority_encoder_scan: RTL and testbench
========================================

Name: priority_encoder_scan

Overview:
Parametrised, sequential successor to the fixed 4-to-2 encoder. It accepts a WIDTH-bit request vector over a valid/ready handshake. It then emits the binary index of every set bit, one beat per cycle, in priority order, with downstream backpressure. It sits between request sources (interrupt lines, grant masks) and consumers that service one index at a time. It also gives a defined output for all-zero and multi-hot inputs, which a plain encoder does not.

Parameters:
- WIDTH, 8: request vector width; must be 2 or greater.
- IDX_W, $clog2(WIDTH): index output width; derived, do not override.
- MSB_FIRST, 0: 0 = bit 0 has highest priority (ascending scan); 1 = bit WIDTH-1 has highest priority (descending scan).

Ports:
- clk, input, 1: rising-edge clock.
- rst_n, input, 1: asynchronous active-low reset.
- in_valid, input, 1: in_vec is valid.
- in_ready, output, 1: block can accept a vector.
- in_vec, input, WIDTH: request vector.
- out_valid, output, 1: out_idx/out_last/out_zero are valid.
- out_ready, input, 1: consumer accepts the current beat.
- out_idx, output, IDX_W: index of the current highest-priority pending bit.
- out_last, output, 1: current beat is the final beat for this vector.
- out_zero, output, 1: accepted vector was all zeros.
- busy, output, 1: a vector is held (state is not IDLE).

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = IDLE; pending register = 0.
  - out_valid = 0, out_idx = 0, out_last = 0, out_zero = 0, busy = 0.
  - in_ready = 1 (follows state), but in_vec is never captured while rst_n is low.
- States: IDLE and EMIT.
- IDLE:
  - in_ready = 1, out_valid = 0.
  - On in_valid && in_ready at a clock edge: pending <= in_vec, zero_flag <= (in_vec == 0), go to EMIT.
- EMIT:
  - in_ready = 0, busy = 1, out_valid = 1.
  - in_valid is ignored and in_vec is not sampled.
- Latency: the first beat is valid in the cycle after acceptance.
- out_idx:
  - MSB_FIRST=0: lowest set bit of pending.
  - MSB_FIRST=1: highest set bit of pending.
  - Derived from registered state only; no combinational path from in_vec.
- out_last = 1 when pending has exactly one bit set, or when zero_flag = 1.
- out_zero = zero_flag. For a zero vector, the single beat is out_idx = 0, out_last = 1, out_zero = 1.
- Handshake:
  - A beat transfers on out_valid && out_ready.
  - On transfer of a non-last beat: clear the emitted bit in pending, stay in EMIT.
  - On transfer of the last beat: pending <= 0, zero_flag <= 0, go to IDLE.
  - in_ready rises in the following cycle; there is no same-cycle re-accept.
- Stall: while out_valid && !out_ready, out_idx, out_last and out_zero hold stable and pending is unchanged.
- Throughput: a vector with N set bits takes N beats (1 for a zero vector) plus 1 IDLE/accept cycle.
- Beat count: exactly popcount(in_vec) beats, or 1 for zero. Each index appears once, in strict priority order.
- Reset mid-EMIT: pending is discarded, out_valid drops immediately (asynchronously), and no further beats are produced for that vector.
- Indices are always below WIDTH. For a non-power-of-2 WIDTH, unused codes are never emitted.

Test Plan:
1. WIDTH=8, MSB_FIRST=0, in_vec=8'b0000_0001, out_ready=1:
   - one beat one cycle after accept: out_idx=0, out_last=1, out_zero=0.
   - in_ready returns to 1 the next cycle.
2. WIDTH=8, MSB_FIRST=0, in_vec=8'b1010_0100, out_ready=1:
   - beats out_idx=2, 5, 7 on consecutive cycles; out_last=1 only on 7.
   - busy=1 across all three beats.
3. WIDTH=8, MSB_FIRST=1, in_vec=8'b1010_0100:
   - beats out_idx=7, 5, 2; out_last on 2.
4. in_vec=8'h00:
   - exactly one beat: out_idx=0, out_zero=1, out_last=1, then IDLE.
5. in_vec=8'hFF with out_ready toggling 1,0,0,1,…, plus in_valid=1 with in_vec=8'h0F held throughout:
   - 8 beats, idx 0..7, each held stable while stalled.
   - in_ready=0 until after idx 7; 8'h0F is accepted only after that.
6. in_vec=8'hFF; after beats 0 and 1, pulse rst_n low mid-cycle:
   - out_valid=0 immediately and busy=0.
   - after release, in_vec=8'h80 yields a single beat out_idx=7, out_last=1.

Source files
------------

// File: rtl/priority_encoder_scan.sv
// priority_encoder_scan
//   Accepts a WIDTH-bit request vector over a valid/ready handshake. It then
//   emits the index of every set bit, one beat per cycle, in priority order.
//   Downstream can apply backpressure on each beat.
//   An all-zero vector produces a single beat flagged with out_zero.
//
// Ports
//   clk, rst_n                  : clock, async active-low reset
//   in_valid/in_ready/in_vec    : request vector handshake
//   out_valid/out_ready         : beat handshake
//   out_idx                     : index of highest-priority pending bit
//   out_last                    : final beat for the held vector
//   out_zero                    : held vector was all zeros
//   busy                        : a vector is held (EMIT state)
module priority_encoder_scan #(
  parameter int WIDTH     = 8,
  parameter int IDX_W     = $clog2(WIDTH),
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_vec,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_last,
  output logic             out_zero,
  output logic             busy
);

  typedef enum logic {IDLE, EMIT} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] pending_q, pending_d;
  logic             zero_q, zero_d;
  logic [IDX_W-1:0] idx;
  logic             onehot;

  // Priority pick from registered state only. The loop runs from lowest to
  // highest priority so that the last match found wins.
  always_comb begin
    idx = '0;
    if (MSB_FIRST) begin
      for (int i = 0; i < WIDTH; i++)
        if (pending_q[i]) idx = IDX_W'(i);
    end else begin
      for (int i = WIDTH - 1; i >= 0; i--)
        if (pending_q[i]) idx = IDX_W'(i);
    end
  end

  // Exactly one bit set: clearing the lowest set bit leaves nothing behind.
  assign onehot = (pending_q != '0) &&
                  ((pending_q & (pending_q - WIDTH'(1))) == '0);

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q == EMIT);
  assign out_valid = (state_q == EMIT);
  assign out_idx   = idx;
  assign out_last  = zero_q | onehot;
  assign out_zero  = zero_q;

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    zero_d    = zero_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          pending_d = in_vec;
          zero_d    = (in_vec == '0);
          state_d   = EMIT;
        end
      end
      EMIT: begin
        if (out_ready) begin
          if (out_last) begin
            pending_d = '0;
            zero_d    = 1'b0;
            state_d   = IDLE;
          end else begin
            pending_d[idx] = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pending_q <= '0;
      zero_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      zero_q    <= zero_d;
    end
  end

endmodule

// File: tb/tb_priority_encoder_scan.sv
module tb_priority_encoder_scan;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] in_valid_s, in_ready_s, out_valid_s, out_last_s, out_zero_s, busy_s;
  logic [7:0] in_vec;
  logic       out_ready;
  logic [2:0] idx_s [2];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  // Instance 0 scans ascending, instance 1 scans descending.
  priority_encoder_scan #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_s[0]), .in_ready(in_ready_s[0]),
    .in_vec(in_vec), .out_valid(out_valid_s[0]), .out_ready(out_ready),
    .out_idx(idx_s[0]), .out_last(out_last_s[0]), .out_zero(out_zero_s[0]),
    .busy(busy_s[0]));

  priority_encoder_scan #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_s[1]), .in_ready(in_ready_s[1]),
    .in_vec(in_vec), .out_valid(out_valid_s[1]), .out_ready(out_ready),
    .out_idx(idx_s[1]), .out_last(out_last_s[1]), .out_zero(out_zero_s[1]),
    .busy(busy_s[1]));

  typedef struct {
    logic [7:0] vec;
    int         sel;   // 0 = ascending instance, 1 = descending instance
    int         nb;
    int         idx[8];
    bit         zero;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one vector with out_ready=1 and check every beat.
  task automatic run_vec(input vec_t v);
    chk("in_ready_before", int'(in_ready_s[v.sel]), 1);
    in_valid_s[v.sel] = 1'b1;
    in_vec            = v.vec;
    out_ready         = 1'b1;
    tick();
    in_valid_s = '0;
    for (int b = 0; b < v.nb; b++) begin
      chk("out_valid", int'(out_valid_s[v.sel]), 1);
      chk("out_idx",   int'(idx_s[v.sel]), v.idx[b]);
      chk("out_last",  int'(out_last_s[v.sel]), (b == v.nb - 1) ? 1 : 0);
      chk("out_zero",  int'(out_zero_s[v.sel]), int'(v.zero));
      chk("busy",      int'(busy_s[v.sel]), 1);
      chk("in_ready_emit", int'(in_ready_s[v.sel]), 0);
      tick();
    end
    chk("out_valid_after", int'(out_valid_s[v.sel]), 0);
    chk("in_ready_after",  int'(in_ready_s[v.sel]), 1);
    chk("busy_after",      int'(busy_s[v.sel]), 0);
  endtask

  initial begin
    tbl[0] = '{vec: 8'b0000_0001, sel: 0, nb: 1, idx: '{0,0,0,0,0,0,0,0}, zero: 1'b0};
    tbl[1] = '{vec: 8'b1010_0100, sel: 0, nb: 3, idx: '{2,5,7,0,0,0,0,0}, zero: 1'b0};
    tbl[2] = '{vec: 8'b1010_0100, sel: 1, nb: 3, idx: '{7,5,2,0,0,0,0,0}, zero: 1'b0};
    tbl[3] = '{vec: 8'h00,        sel: 0, nb: 1, idx: '{0,0,0,0,0,0,0,0}, zero: 1'b1};
    tbl[4] = '{vec: 8'h00,        sel: 1, nb: 1, idx: '{0,0,0,0,0,0,0,0}, zero: 1'b1};
    tbl[5] = '{vec: 8'b1000_0001, sel: 1, nb: 2, idx: '{7,0,0,0,0,0,0,0}, zero: 1'b0};
    tbl[6] = '{vec: 8'b0001_1000, sel: 0, nb: 2, idx: '{3,4,0,0,0,0,0,0}, zero: 1'b0};
    tbl[7] = '{vec: 8'hFF,        sel: 1, nb: 8, idx: '{7,6,5,4,3,2,1,0}, zero: 1'b0};

    // Reset with a request present: it must not be captured.
    rst_n      = 1'b0;
    in_valid_s = 2'b11;
    in_vec     = 8'hFF;
    out_ready  = 1'b0;
    tick();
    tick();
    for (int s = 0; s < 2; s++) begin
      chk("rst_out_valid", int'(out_valid_s[s]), 0);
      chk("rst_out_idx",   int'(idx_s[s]), 0);
      chk("rst_out_last",  int'(out_last_s[s]), 0);
      chk("rst_out_zero",  int'(out_zero_s[s]), 0);
      chk("rst_busy",      int'(busy_s[s]), 0);
      chk("rst_in_ready",  int'(in_ready_s[s]), 1);
    end
    in_valid_s = '0;
    rst_n      = 1'b1;
    tick();

    for (int t = 0; t < 8; t++) run_vec(tbl[t]);

    // Stall pattern 1,0,0,1,... with a second request waiting the whole time.
    begin
      int beat = 0;
      int cyc  = 0;
      in_valid_s[0] = 1'b1;
      in_vec        = 8'hFF;
      out_ready     = 1'b0;
      tick();
      in_vec = 8'h0F;
      while (beat < 8 && cyc < 200) begin
        out_ready = (cyc % 3 == 0);
        chk("stall_out_valid", int'(out_valid_s[0]), 1);
        chk("stall_out_idx",   int'(idx_s[0]), beat);
        chk("stall_out_last",  int'(out_last_s[0]), (beat == 7) ? 1 : 0);
        chk("stall_in_ready",  int'(in_ready_s[0]), 0);
        if (out_ready) beat++;
        cyc++;
        tick();
      end
      chk("stall_beats_done", beat, 8);
      // Back in IDLE with in_valid still high: 8'h0F is taken at this edge.
      chk("stall_in_ready_idle", int'(in_ready_s[0]), 1);
      chk("stall_out_valid_idle", int'(out_valid_s[0]), 0);
      out_ready = 1'b1;
      tick();
      in_valid_s = '0;
      for (int b = 0; b < 4; b++) begin
        chk("next_out_valid", int'(out_valid_s[0]), 1);
        chk("next_out_idx",   int'(idx_s[0]), b);
        chk("next_out_last",  int'(out_last_s[0]), (b == 3) ? 1 : 0);
        tick();
      end
      chk("next_idle", int'(out_valid_s[0]), 0);
    end

    // Reset in the middle of a vector.
    in_valid_s[0] = 1'b1;
    in_vec        = 8'hFF;
    out_ready     = 1'b1;
    tick();
    in_valid_s = '0;
    chk("mid_idx0", int'(idx_s[0]), 0);
    tick();
    chk("mid_idx1", int'(idx_s[0]), 1);
    tick();
    chk("mid_idx2_valid", int'(out_valid_s[0]), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", int'(out_valid_s[0]), 0);
    chk("mid_rst_busy",      int'(busy_s[0]), 0);
    chk("mid_rst_in_ready",  int'(in_ready_s[0]), 1);
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_out_valid", int'(out_valid_s[0]), 0);
    run_vec('{vec: 8'h80, sel: 0, nb: 1, idx: '{7,0,0,0,0,0,0,0}, zero: 1'b0});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
